mem_test_sequencer: RTL
=======================

Name: mem_test_sequencer

Overview:
- Sequences a write-then-read-back test over the 14-bit-address, 64-bit-data test memory.
- Generates the write patterns and the expected read data, and compares each read word with the expected word.
- Counts mismatches and captures the first failing address and data for the error reporting path.
- Sits between the host/test control registers and the memory port; replaces free-running pattern drivers.

Parameters:
- ADDR_W, 14, memory address width
- DATA_W, 64, memory data width (multiple of 16)
- RD_LAT, 1, cycles from mem_re/mem_addr to valid mem_rdata (1..4)
- CNT_W, 16, error counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a test when idle
- abort  in  1  one-cycle pulse; terminates the test
- pattern_sel  in  2  0 zeros, 1 ones, 2 checkerboard, 3 address-in-data
- addr_last  in  ADDR_W  last address tested (range 0..addr_last)
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_re
- busy  out  1  high from the cycle after start until the return to IDLE
- done  out  1  one-cycle pulse on normal completion
- pass  out  1  high when the last completed test had zero errors
- err_flag  out  1  sticky; set on the first mismatch of a test
- err_count  out  CNT_W  mismatches in the current/last test, saturating
- err_addr  out  ADDR_W  address of the first mismatch
- err_data  out  DATA_W  read data of the first mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, compare pipeline cleared.
- Patterns: P(a) for address a.
  - sel 0: all zeros.
  - sel 1: all ones.
  - sel 2: 0xAAAA_AAAA_AAAA_AAAA at even a, 0x5555_5555_5555_5555 at odd a.
  - sel 3: the 16-bit word {2'b00, a} replicated DATA_W/16 times.
- pattern_sel and addr_last are latched on start; later input changes are ignored.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - start moves to WRITE.
  - On start, err_flag, err_count, err_addr, err_data and pass clear.
- WRITE:
  - mem_we=1, mem_addr=a, mem_wdata=P(a).
  - a runs 0..addr_last, one per cycle.
  - After the addr_last write, go to READ with a=0.
- READ:
  - mem_re=1, mem_addr=a, a runs 0..addr_last.
  - Each cycle, push {valid, a, P(a)} into an RD_LAT-deep shift pipeline.
  - After addr_last, go to DRAIN.
- DRAIN:
  - RD_LAT cycles; mem_re=0; the pipeline keeps shifting with valid=0 inserted.
  - Then go to DONE.
- Compare (any state):
  - When the pipeline output is valid and mem_rdata != expected: err_count += 1, saturating at all-ones.
  - On the first mismatch of a test only: err_flag=1, and err_addr/err_data capture that entry's address and mem_rdata.
- DONE:
  - done=1 for one cycle; pass = (err_count==0 including the final compare); go to IDLE.
  - busy is still 1 in DONE and is 0 in IDLE.
- Latency: with addr_last=N, done rises 2(N+1)+RD_LAT+1 cycles after the cycle start is sampled.
- addr_last=0 is legal: one write, one read.
- mem_we and mem_re are never high together. Both are 0 outside WRITE/READ.
- start while busy is ignored.
- abort (busy only):
  - Next state is IDLE and the pipeline is flushed.
  - No done pulse; pass=0.
  - err_* keep their values.
- abort and start in the same cycle in IDLE: start wins; abort is ignored when idle.
- Reset mid-test: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared package mem_test_pkg:
  - ADDR_W/DATA_W defaults
  - state enum
  - pattern_sel encodings
  - checkerboard constants
  - pattern function P(sel, a)
- One natural sub-module, mem_test_cmp_pipe: the RD_LAT-deep {valid, addr, expected} shift register plus comparator, outputs mismatch/addr.
- FSM, counters and error capture stay in the top module.

Test Plan:
- Clean memory model, sel=0, addr_last=7, RD_LAT=1 -> 8 writes of 0 at addr 0..7, then 8 reads; done at cycle 18 after start; pass=1, err_count=0, err_flag=0.
- sel=3, addr_last=3, model corrupts bit 0 at addr 2 -> err_count=1, err_addr=2, err_data=0x0002_0002_0002_0003, pass=0.
- sel=2, addr_last=15, stuck-at-0 model (reads return 0) -> err_count=16, err_addr=0, err_data=0; all reads compared, including the last one, in DRAIN.
- RD_LAT=3, sel=1, addr_last=0 -> exactly one mem_we and one mem_re pulse; done 6 cycles after start; pass=1.
- abort in READ at addr 5 with one earlier error -> busy falls the next cycle, no done pulse, pass=0, err_count=1 retained; a new start clears it.
- start pulses while busy, plus rst_n low mid-WRITE -> extra starts have no effect; on reset all outputs are 0 immediately and the FSM is in IDLE.

Source files
------------

// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared types, constants and pattern generator for the memory test sequencer
package mem_test_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 64;
  localparam logic [15:0] CHK_EVEN = 16'hAAAA;
  localparam logic [15:0] CHK_ODD = 16'h5555;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {PAT_ZEROS, PAT_ONES, PAT_CHECKER, PAT_ADDR} pat_t;
  function automatic logic [15:0] pattern_word(input pat_t sel, input logic [15:0] a);
    return sel == PAT_ZEROS ? 16'h0000 :
           sel == PAT_ONES ? 16'hFFFF :
           sel == PAT_CHECKER ? (a[0] ? CHK_ODD : CHK_EVEN) : a;
  endfunction
endpackage

// File: rtl/mem_test_cmp_pipe.sv
// mem_test_cmp_pipe: read-latency-matched expected-data pipeline with read-back comparator
module mem_test_cmp_pipe #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_exp,
  input  logic [DATA_W-1:0] rdata,
  output logic              mismatch,
  output logic [ADDR_W-1:0] mis_addr
);
  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0][DATA_W-1:0] exp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      addr_q <= '0;
      exp_q <= '0;
    end else begin
      vld[0] <= push && !flush;
      addr_q[0] <= push_addr;
      exp_q[0] <= push_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1] && !flush;
        addr_q[i] <= addr_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end
  assign mismatch = vld[RD_LAT-1] && rdata != exp_q[RD_LAT-1];
  assign mis_addr = addr_q[RD_LAT-1];
endmodule

// File: rtl/mem_test_sequencer.sv
// mem_test_sequencer: write-then-read-back memory test with pattern generation and error capture
module mem_test_sequencer
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pattern_sel,
  input  logic [ADDR_W-1:0] addr_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
);
  state_t state, state_nx;
  pat_t sel_q;
  logic [ADDR_W-1:0] a, a_nx, last_q, mis_addr;
  logic [DATA_W-1:0] pat;
  logic [CNT_W-1:0] cnt_nx;
  logic at_last, mismatch, kill;
  assign at_last = a == last_q;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign mem_we = state == S_WRITE;
  assign mem_re = state == S_READ;
  assign mem_addr = (mem_we || mem_re) ? a : '0;
  assign pat = {(DATA_W/16){pattern_word(sel_q, 16'(a))}};
  assign mem_wdata = mem_we ? pat : '0;
  assign kill = abort && busy;
  assign cnt_nx = err_count + CNT_W'(mismatch && !(&err_count));
  always_comb begin
    state_nx = state;
    a_nx = a;
    if (kill) begin
      state_nx = S_IDLE;
      a_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = start ? S_WRITE : S_IDLE;
          a_nx = '0;
        end
        S_WRITE: begin
          state_nx = at_last ? S_READ : S_WRITE;
          a_nx = at_last ? '0 : a + ADDR_W'(1);
        end
        S_READ: begin
          state_nx = at_last ? S_DRAIN : S_READ;
          a_nx = at_last ? '0 : a + ADDR_W'(1);
        end
        S_DRAIN: begin
          state_nx = a == ADDR_W'(RD_LAT - 1) ? S_DONE : S_DRAIN;
          a_nx = a == ADDR_W'(RD_LAT - 1) ? '0 : a + ADDR_W'(1);
        end
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a <= '0;
      sel_q <= PAT_ZEROS;
      last_q <= '0;
      pass <= 1'b0;
      err_flag <= 1'b0;
      err_count <= '0;
      err_addr <= '0;
      err_data <= '0;
    end else begin
      state <= state_nx;
      a <= a_nx;
      if (state == S_IDLE && start) begin
        sel_q <= pat_t'(pattern_sel);
        last_q <= addr_last;
        pass <= 1'b0;
        err_flag <= 1'b0;
        err_count <= '0;
        err_addr <= '0;
        err_data <= '0;
      end else begin
        err_count <= cnt_nx;
        if (mismatch && !err_flag) begin
          err_flag <= 1'b1;
          err_addr <= mis_addr;
          err_data <= mem_rdata;
        end
        if (kill) pass <= 1'b0;
        else if (state_nx == S_DONE) pass <= cnt_nx == '0;
      end
    end
  end
  mem_test_cmp_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_cmp (
    .clk(clk),
    .rst_n(rst_n),
    .flush(kill),
    .push(mem_re),
    .push_addr(mem_addr),
    .push_exp(pat),
    .rdata(mem_rdata),
    .mismatch(mismatch),
    .mis_addr(mis_addr)
  );
endmodule
